control_unit: RTL

//  Multi-cycle fetch/decode/execute sequencer that sits directly upstream of datapath.

---
 rtl/control_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/control_unit.sv
`timescale 1ns/1ps
// control_unit: three-cycle fetch/decode/execute sequencer that drives the
// datapath control inputs from a 16-bit instruction register.
module control_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int RADDR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [15:0]            imem_data,
  output logic                   alu_en,
  output logic [2:0]             alu_opcode,
  output logic [RADDR_WIDTH-1:0] ra_addr,
  output logic [RADDR_WIDTH-1:0] rb_addr,
  output logic [RADDR_WIDTH-1:0] write_addr,
  output logic [7:0]             user_write_data,
  output logic                   write_en,
  input  logic                   alu_zero,
  input  logic                   alu_carry,
  output logic                   flag_z,
  output logic                   flag_c,
  output logic                   halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALTED
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic                flag_z_q, flag_z_d;
  logic                flag_c_q, flag_c_d;

  logic is_alu, is_ldi, is_jmp, is_bz, is_bc, is_halt, take_jump;

  assign is_alu    = ~ir_q[15];
  assign is_ldi    = (ir_q[15:12] == 4'b1000);
  assign is_jmp    = (ir_q[15:12] == 4'b1001);
  assign is_bz     = (ir_q[15:12] == 4'b1010);
  assign is_bc     = (ir_q[15:12] == 4'b1011);
  assign is_halt   = (ir_q[15:12] == 4'b1111);
  // Branches test the flags latched by an earlier ALU op, not the live ALU flags.
  assign take_jump = is_jmp | (is_bz & flag_z_q) | (is_bc & flag_c_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  // NOTE: every signal written here gets a default first so no path through
  // the case statement leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    write_en = 1'b0;
    alu_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = imem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        write_en = is_alu | is_ldi;
        alu_en   = is_alu;
        if (is_halt) begin
          state_d = S_HALTED;
        end else begin
          state_d = run ? S_FETCH : S_IDLE;
          if (is_alu) begin
            flag_z_d = alu_zero;
            flag_c_d = alu_carry;
          end
          if (take_jump) pc_d = PC_WIDTH'(ir_q[7:0]);
          else           pc_d = pc_q + PC_WIDTH'(1);
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_addr       = pc_q;
  assign alu_opcode      = ir_q[14:12];
  assign write_addr      = RADDR_WIDTH'(ir_q[11:8]);
  assign ra_addr         = RADDR_WIDTH'(ir_q[7:4]);
  assign rb_addr         = RADDR_WIDTH'(ir_q[3:0]);
  assign user_write_data = ir_q[7:0];
  assign flag_z          = flag_z_q;
  assign flag_c          = flag_c_q;
  assign halted          = (state_q == S_HALTED);

endmodule
